// File: rtl/nibble_loader.sv
// Assembles a W-bit word from NNIB nibbles, MS nibble first, and offers it downstream
// on a valid/ready handshake with backpressure and overflow reporting.
module nibble_loader #(
  parameter int unsigned NW   = 4,
  parameter int unsigned NNIB = 5,
  parameter int unsigned CW   = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic [NW-1:0]        DIN,
  input  logic                 DIN_VALID,
  input  logic                 Y_READY,
  output logic [NW*NNIB-1:0]   Y,
  output logic                 Y_VALID,
  output logic                 BUSY,
  output logic [CW-1:0]        CNT,
  output logic                 OVF
);

  localparam int unsigned W = NW * NNIB;

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e       state;
  logic [W-1:0] sr;
  logic [W-1:0] sr_shift;

  assign sr_shift = {sr[W-NW-1:0], DIN};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= StIdle;
      sr      <= '0;
      Y       <= '0;
      Y_VALID <= 1'b0;
      BUSY    <= 1'b0;
      CNT     <= '0;
      OVF     <= 1'b0;
    end else begin
      OVF <= 1'b0;
      if (CLR) begin
        // Abort discards any nibble and handshake this cycle; Y keeps its last word.
        state   <= StIdle;
        sr      <= '0;
        Y_VALID <= 1'b0;
        BUSY    <= 1'b0;
        CNT     <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (DIN_VALID) begin
              sr    <= sr_shift;
              CNT   <= CW'(1);
              BUSY  <= 1'b1;
              state <= StLoad;
            end
          end
          StLoad: begin
            if (DIN_VALID) begin
              sr <= sr_shift;
              if (CNT == CW'(NNIB - 1)) begin
                Y       <= sr_shift;
                Y_VALID <= 1'b1;
                CNT     <= '0;
                BUSY    <= 1'b0;
                state   <= StFull;
              end else begin
                CNT <= CNT + CW'(1);
              end
            end
          end
          StFull: begin
            if (Y_READY) begin
              Y_VALID <= 1'b0;
              if (DIN_VALID) begin
                // Drain and start the next word on the same edge.
                sr    <= sr_shift;
                CNT   <= CW'(1);
                BUSY  <= 1'b1;
                state <= StLoad;
              end else begin
                state <= StIdle;
              end
            end else if (DIN_VALID) begin
              OVF <= 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nibble_loader.sv
// Directed and randomized bench for nibble_loader, checked every cycle against a
// queue-based model plus literal expectations for the directed sequences.
module tb_nibble_loader;

  logic        CLK;
  logic        RST;
  logic        CLR;
  logic [3:0]  DIN;
  logic        DIN_VALID;
  logic        Y_READY;
  logic [19:0] Y;
  logic        Y_VALID;
  logic        BUSY;
  logic [2:0]  CNT;
  logic        OVF;

  int vectors;
  int miscompares;
  bit armed;

  nibble_loader #(.NW(4), .NNIB(5), .CW(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .Y_READY   (Y_READY),
    .Y         (Y),
    .Y_VALID   (Y_VALID),
    .BUSY      (BUSY),
    .CNT       (CNT),
    .OVF       (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: nibbles of the word in progress, whether a finished word is pending, last word.
  bit [3:0]  m_q[$];
  bit        m_full;
  bit [19:0] m_y;
  bit        m_ovf;

  function automatic bit [19:0] pack_word();
    bit [19:0] w = '0;
    foreach (m_q[i]) w = (w << 4) | 20'(m_q[i]);
    return w;
  endfunction

  always @(posedge CLK) begin
    m_ovf = 1'b0;
    if (RST) begin
      m_q.delete();
      m_full = 1'b0;
      m_y    = '0;
    end else if (CLR) begin
      m_q.delete();
      m_full = 1'b0;
    end else if (m_full) begin
      if (Y_READY) begin
        m_full = 1'b0;
        if (DIN_VALID) m_q.push_back(DIN);
      end else if (DIN_VALID) begin
        m_ovf = 1'b1;
      end
    end else if (DIN_VALID) begin
      m_q.push_back(DIN);
      if (m_q.size() == 5) begin
        m_y = pack_word();
        m_q.delete();
        m_full = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      chk("model_y",     32'(Y),       32'(m_y));
      chk("model_valid", 32'(Y_VALID), 32'(m_full));
      chk("model_busy",  32'(BUSY),    32'(m_q.size() != 0));
      chk("model_cnt",   32'(CNT),     32'(m_q.size()));
      chk("model_ovf",   32'(OVF),     32'(m_ovf));
    end
  end

  task automatic step(input bit rst, input bit clr, input bit v, input bit [3:0] d,
                      input bit rdy);
    @(negedge CLK);
    RST = rst; CLR = clr; DIN_VALID = v; DIN = d; Y_READY = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic nib(input bit [3:0] d, input bit rdy);
    step(1'b0, 1'b0, 1'b1, d, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 4'h0, rdy);
  endtask

  initial begin
    vectors = 0; miscompares = 0; armed = 1'b0;
    RST = 1'b1; CLR = 1'b0; DIN = '0; DIN_VALID = 1'b0; Y_READY = 1'b0;

    // Basic load
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    armed = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("rst_y", 32'(Y), 32'h0);
    chk("rst_valid", 32'(Y_VALID), 32'h0);
    chk("rst_cnt", 32'(CNT), 32'h0);
    chk("rst_busy_ovf", 32'({BUSY, OVF}), 32'h0);
    for (int i = 0; i < 4; i++) begin
      nib(4'(4'hA + i), 1'b0);
      chk("load_cnt", 32'(CNT), 32'(i + 1));
      chk("load_busy", 32'(BUSY), 32'h1);
    end
    nib(4'hE, 1'b0);
    chk("load_y", 32'(Y), 32'hABCDE);
    chk("load_valid", 32'(Y_VALID), 32'h1);
    chk("load_cnt_done", 32'(CNT), 32'h0);
    chk("load_busy_done", 32'(BUSY), 32'h0);

    // Backpressure / overflow
    nib(4'h7, 1'b0);
    chk("ovf_pulse", 32'(OVF), 32'h1);
    chk("ovf_y_hold", 32'(Y), 32'hABCDE);
    idle(1'b0);
    chk("ovf_clear", 32'(OVF), 32'h0);
    idle(1'b1);
    chk("drain_valid", 32'(Y_VALID), 32'h0);
    chk("drain_y_kept", 32'(Y), 32'hABCDE);

    // Simultaneous drain and load
    for (int i = 0; i < 5; i++) nib(4'(9 - i), 1'b0);
    chk("fill_y", 32'(Y), 32'h98765);
    nib(4'h1, 1'b1);
    chk("sim_valid", 32'(Y_VALID), 32'h0);
    chk("sim_cnt", 32'(CNT), 32'h1);
    chk("sim_ovf", 32'(OVF), 32'h0);
    for (int i = 2; i <= 5; i++) nib(4'(i), 1'b0);
    chk("sim_y", 32'(Y), 32'h12345);
    chk("sim_valid2", 32'(Y_VALID), 32'h1);

    // Gapped input
    idle(1'b1);
    for (int i = 0; i < 5; i++) begin
      nib((i % 2 == 0) ? 4'hF : 4'h0, 1'b0);
      if (i < 4) begin
        for (int g = 0; g < 3; g++) idle(1'b0);
        chk("gap_cnt", 32'(CNT), 32'(i + 1));
      end
    end
    chk("gap_y", 32'(Y), 32'hF0F0F);

    // Abort
    idle(1'b1);
    for (int i = 0; i < 3; i++) nib(4'h6, 1'b0);
    chk("clr_pre_cnt", 32'(CNT), 32'h3);
    step(1'b0, 1'b1, 1'b1, 4'h9, 1'b0);
    chk("clr_cnt", 32'(CNT), 32'h0);
    chk("clr_busy_ovf", 32'({BUSY, OVF}), 32'h0);
    chk("clr_y_kept", 32'(Y), 32'hF0F0F);
    for (int i = 1; i <= 5; i++) nib(4'(i), 1'b0);
    chk("clr_y", 32'(Y), 32'h12345);

    // Reset mid-word and while full
    nib(4'h1, 1'b1);
    nib(4'h2, 1'b0);
    chk("rst_mid_pre", 32'(CNT), 32'h2);
    step(1'b1, 1'b0, 1'b1, 4'h3, 1'b0);
    chk("rst_mid_cnt", 32'(CNT), 32'h0);
    chk("rst_mid_busy", 32'(BUSY), 32'h0);
    chk("rst_mid_y", 32'(Y), 32'h0);
    for (int i = 0; i < 5; i++) nib(4'hC, 1'b0);
    chk("rst_full_pre", 32'(Y), 32'hCCCCC);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("rst_full_valid", 32'(Y_VALID), 32'h0);
    chk("rst_full_y", 32'(Y), 32'h0);

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 9) < 4));
    end

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
